// File: rtl/gpo_seq_pkg.sv
// gpo_seq_pkg: shared states and constants for the GPO pattern sequencer
package gpo_seq_pkg;
  localparam int STEPS_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int GPO_PIN_EN_BIT = 7;
  localparam logic [7:0] GPO_CLEAR = 8'h00;
  typedef enum logic [1:0] {IDLE, WRITE, WAIT, STOP} seq_state_e;
endpackage

// File: rtl/gpo_seq_ctrl_if.sv
// gpo_seq_ctrl_if: pattern/sequencer control, host register access and GPO register bus
interface gpo_seq_ctrl_if #(
  parameter int STEPS = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(STEPS);
  logic pat_we;
  logic [AW-1:0] pat_addr;
  logic [DATA_W-1:0] pat_data;
  logic seq_start;
  logic seq_stop;
  logic [AW-1:0] seq_len;
  logic [CNT_W-1:0] step_ticks;
  logic loop_en;
  logic host_wr_req;
  logic [DATA_W-1:0] host_wdata;
  logic host_ack;
  logic host_rd_req;
  logic [DATA_W-1:0] host_rdata;
  logic host_rvalid;
  logic gpo_wr_en;
  logic [DATA_W-1:0] gpo_wdata;
  logic gpo_rd_en;
  logic [DATA_W-1:0] gpo_rdata;
  logic seq_busy;
  logic [AW-1:0] seq_step;
  logic seq_done;
  modport slave (
    input pat_we, pat_addr, pat_data, seq_start, seq_stop, seq_len, step_ticks, loop_en,
    input host_wr_req, host_wdata, host_rd_req, gpo_rdata,
    output host_ack, host_rdata, host_rvalid, gpo_wr_en, gpo_wdata, gpo_rd_en,
    output seq_busy, seq_step, seq_done
  );
  modport master (
    output pat_we, pat_addr, pat_data, seq_start, seq_stop, seq_len, step_ticks, loop_en,
    output host_wr_req, host_wdata, host_rd_req, gpo_rdata,
    input host_ack, host_rdata, host_rvalid, gpo_wr_en, gpo_wdata, gpo_rd_en,
    input seq_busy, seq_step, seq_done
  );
endinterface

// File: rtl/gpo_step_timer.sv
// gpo_step_timer: loadable dwell down-counter, expire flags the final count of 1
module gpo_step_timer #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic expire
);
  always_ff @(posedge clk or posedge reset)
    if (reset) value <= '0;
    else if (load) value <= load_val;
    else if (dec && value != '0) value <= value - 1'b1;
  assign expire = value == CNT_W'(1);
endmodule

// File: rtl/gpo_seq_ctrl.sv
// gpo_seq_ctrl: timed pattern sequencer owning the GPO register port, with host write
// arbitration (sequencer first) and a 3-cycle host readback path
module gpo_seq_ctrl
  import gpo_seq_pkg::*;
#(
  parameter int STEPS = STEPS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  gpo_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(STEPS);
  seq_state_e state, nxt;
  logic [DATA_W-1:0] pat [STEPS];
  logic [AW-1:0] step, step_nxt, len_q;
  logic [CNT_W-1:0] ticks_q, ticks_eff, cnt;
  logic loop_q, expire, last, seq_wr, host_grant, fin_next, rd_cap;
  gpo_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(state == WRITE),
    .dec(state == WAIT),
    .load_val(ticks_eff),
    .value(cnt),
    .expire(expire)
  );
  always_comb begin
    ticks_eff = (ticks_q == '0) ? CNT_W'(1) : ticks_q;
    last = step == len_q;
    case (state)
      IDLE: nxt = (bus.seq_start && !bus.seq_stop) ? WRITE : IDLE;
      WRITE: nxt = bus.seq_stop ? STOP : WAIT;
      WAIT: nxt = bus.seq_stop ? STOP : !expire ? WAIT : (!last || loop_q) ? WRITE : IDLE;
      default: nxt = IDLE;
    endcase
    step_nxt = (nxt == WRITE) ? ((state == IDLE || last) ? '0 : step + 1'b1) : step;
    seq_wr = nxt == WRITE || nxt == STOP;
    host_grant = bus.host_wr_req && !bus.host_ack && !seq_wr;
    // done is registered one cycle early so it lands on the final dwell cycle
    fin_next = last && !loop_q && !bus.seq_stop &&
               ((state == WRITE && ticks_eff == CNT_W'(1)) || (state == WAIT && cnt == CNT_W'(2)));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      step <= '0;
      len_q <= '0;
      ticks_q <= '0;
      loop_q <= 1'b0;
      rd_cap <= 1'b0;
      bus.gpo_wr_en <= 1'b0;
      bus.gpo_wdata <= '0;
      bus.gpo_rd_en <= 1'b0;
      bus.host_ack <= 1'b0;
      bus.host_rdata <= '0;
      bus.host_rvalid <= 1'b0;
      bus.seq_busy <= 1'b0;
      bus.seq_done <= 1'b0;
      for (int i = 0; i < STEPS; i++) pat[i] <= '0;
    end else begin
      state <= nxt;
      step <= step_nxt;
      if (state == IDLE && nxt == WRITE) begin
        len_q <= bus.seq_len;
        ticks_q <= bus.step_ticks;
        loop_q <= bus.loop_en;
      end
      bus.gpo_wr_en <= seq_wr || host_grant;
      bus.gpo_wdata <= (nxt == STOP) ? DATA_W'(GPO_CLEAR) : (nxt == WRITE) ? pat[step_nxt] :
                       host_grant ? bus.host_wdata : bus.gpo_wdata;
      bus.host_ack <= host_grant;
      bus.seq_busy <= nxt != IDLE;
      bus.seq_done <= fin_next;
      bus.gpo_rd_en <= bus.host_rd_req && !bus.gpo_rd_en && !rd_cap;
      rd_cap <= bus.gpo_rd_en;
      bus.host_rvalid <= rd_cap;
      if (rd_cap) bus.host_rdata <= bus.gpo_rdata;
      if (bus.pat_we) pat[bus.pat_addr] <= bus.pat_data;
    end
  assign bus.seq_step = step;
endmodule

// File: tb/tb_gpo_seq_ctrl.sv
// tb_gpo_seq_ctrl: randomized scenario bench with a cycle-arithmetic sequencer model
module tb_gpo_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [7:0] pat_m [8];
  logic [7:0] gpo_q;
  logic [7:0] cur;
  always #5 clk = ~clk;
  gpo_seq_ctrl_if #(.STEPS(8), .DATA_W(8), .CNT_W(16)) bus ();
  gpo_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  // GPO register block: registered read data, zero when not reading
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gpo_q <= 8'h00;
      bus.gpo_rdata <= 8'h00;
    end else begin
      if (bus.gpo_wr_en) gpo_q <= bus.gpo_wdata;
      bus.gpo_rdata <= bus.gpo_rd_en ? gpo_q : 8'h00;
    end
  function automatic logic [24:0] out_vec();
    return {bus.host_ack, bus.host_rdata, bus.host_rvalid, bus.gpo_wr_en, bus.gpo_wdata,
            bus.gpo_rd_en, bus.seq_busy, bus.seq_step, bus.seq_done};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.pat_we = 1'b0;
    bus.pat_addr = '0;
    bus.pat_data = '0;
    bus.seq_start = 1'b0;
    bus.seq_stop = 1'b0;
    bus.seq_len = '0;
    bus.step_ticks = '0;
    bus.loop_en = 1'b0;
    bus.host_wr_req = 1'b0;
    bus.host_wdata = '0;
    bus.host_rd_req = 1'b0;
  endtask
  task automatic load_entry(input int a, input logic [7:0] d);
    bus.pat_we = 1'b1;
    bus.pat_addr = 3'(a);
    bus.pat_data = d;
    tick();
    bus.pat_we = 1'b0;
    pat_m[a] = d;
  endtask
  // start a sequence and check ncyc cycles: step k writes pat[k mod (len+1)] every 1+max(ticks,1) cycles
  task automatic run_seq(input int len, input int ticks, input bit lp, input int ncyc, input string tag);
    int p, w, idx;
    logic ew, ed, eb;
    logic [7:0] edat;
    logic [2:0] es;
    p = (ticks == 0 ? 1 : ticks) + 1;
    w = len + 1;
    bus.seq_len = 3'(len);
    bus.step_ticks = 16'(ticks);
    bus.loop_en = lp;
    bus.seq_start = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      idx = (k - 1) / p;
      eb = lp || k <= w * p;
      ew = eb && ((k - 1) % p == 0);
      edat = pat_m[idx % w];
      ed = !lp && k == w * p;
      es = eb ? 3'(idx % w) : 3'(len);
      checks += 4;
      if (bus.gpo_wr_en !== ew) begin
        errors++;
        $display("FAIL %s wr_en k=%0d: got %b want %b", tag, k, bus.gpo_wr_en, ew);
      end
      if (bus.seq_done !== ed) begin
        errors++;
        $display("FAIL %s seq_done k=%0d: got %b want %b", tag, k, bus.seq_done, ed);
      end
      if (bus.seq_busy !== eb) begin
        errors++;
        $display("FAIL %s seq_busy k=%0d: got %b want %b", tag, k, bus.seq_busy, eb);
      end
      if (bus.seq_step !== es) begin
        errors++;
        $display("FAIL %s seq_step k=%0d: got %0d want %0d", tag, k, bus.seq_step, es);
      end
      if (ew) begin
        checks++;
        if (bus.gpo_wdata !== edat) begin
          errors++;
          $display("FAIL %s wdata k=%0d: got %h want %h", tag, k, bus.gpo_wdata, edat);
        end
      end
      if (k < ncyc) tick();
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h want 0", out_vec());
    end
    reset = 1'b0;
    tick();
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL idle after reset outputs: got %h want 0", out_vec());
    end
  endtask
  task automatic test_basic();
    load_entry(0, 8'h81);
    load_entry(1, 8'h82);
    load_entry(2, 8'h84);
    load_entry(3, 8'h88);
    run_seq(3, 2, 1'b0, 14, "basic");
  endtask
  task automatic test_random_seq();
    int len, ticks;
    repeat (4) begin
      for (int i = 0; i < 8; i++) load_entry(i, 8'($urandom));
      len = $urandom_range(0, 7);
      ticks = $urandom_range(0, 4);
      run_seq(len, ticks, 1'b0, (len + 1) * ((ticks == 0 ? 1 : ticks) + 1) + 2, "random");
    end
  endtask
  task automatic test_loop_stop();
    load_entry(0, 8'h81);
    load_entry(1, 8'h82);
    load_entry(2, 8'h84);
    load_entry(3, 8'h88);
    run_seq(3, 2, 1'b1, 14, "loop");
    bus.seq_stop = 1'b1;
    tick();
    bus.seq_stop = 1'b0;
    checks++;
    if ({bus.gpo_wr_en, bus.gpo_wdata, bus.seq_busy, bus.seq_done} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stop write: got wr=%b d=%h busy=%b done=%b want 1 00 1 0",
               bus.gpo_wr_en, bus.gpo_wdata, bus.seq_busy, bus.seq_done);
    end
    repeat (3) begin
      tick();
      checks++;
      if ({bus.gpo_wr_en, bus.seq_busy, bus.seq_done, bus.seq_step} !== 6'b0) begin
        errors++;
        $display("FAIL after stop: got wr=%b busy=%b done=%b step=%0d want 0 0 0 0",
                 bus.gpo_wr_en, bus.seq_busy, bus.seq_done, bus.seq_step);
      end
    end
  endtask
  task automatic test_host_arb();
    int n;
    bus.seq_len = 3'd0;
    bus.step_ticks = 16'd5;
    bus.loop_en = 1'b0;
    bus.seq_start = 1'b1;
    bus.host_wr_req = 1'b1;
    bus.host_wdata = 8'hFF;
    tick();
    bus.seq_start = 1'b0;
    checks++;
    if ({bus.gpo_wr_en, bus.gpo_wdata, bus.host_ack} !== {1'b1, pat_m[0], 1'b0}) begin
      errors++;
      $display("FAIL arb seq write: got wr=%b d=%h ack=%b want 1 %h 0",
               bus.gpo_wr_en, bus.gpo_wdata, bus.host_ack, pat_m[0]);
    end
    tick();
    bus.host_wr_req = 1'b0;
    checks++;
    if ({bus.gpo_wr_en, bus.gpo_wdata, bus.host_ack} !== {1'b1, 8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL arb host write: got wr=%b d=%h ack=%b want 1 ff 1",
               bus.gpo_wr_en, bus.gpo_wdata, bus.host_ack);
    end
    tick();
    checks++;
    if ({bus.gpo_wr_en, bus.host_ack} !== 2'b00) begin
      errors++;
      $display("FAIL arb single ack: got wr=%b ack=%b want 0 0", bus.gpo_wr_en, bus.host_ack);
    end
    for (n = 0; n < 20 && bus.seq_busy; n++) tick();
    checks++;
    if (bus.seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL arb finish timeout: busy=%b want 0", bus.seq_busy);
    end
  endtask
  task automatic host_write(input logic [7:0] d, input string tag);
    bus.host_wr_req = 1'b1;
    bus.host_wdata = d;
    tick();
    bus.host_wr_req = 1'b0;
    checks++;
    if ({bus.host_ack, bus.gpo_wr_en, bus.gpo_wdata} !== {2'b11, d}) begin
      errors++;
      $display("FAIL %s host write: got ack=%b wr=%b d=%h want 1 1 %h",
               tag, bus.host_ack, bus.gpo_wr_en, bus.gpo_wdata, d);
    end
    cur = d;
  endtask
  task automatic test_readback();
    int hold;
    logic [7:0] d;
    host_write(8'hA5, "readback");
    tick();
    bus.host_rd_req = 1'b1;
    tick();
    bus.host_rd_req = 1'b0;
    checks++;
    if ({bus.gpo_rd_en, bus.host_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL rd +1: got rd_en=%b rvalid=%b want 1 0", bus.gpo_rd_en, bus.host_rvalid);
    end
    tick();
    checks++;
    if ({bus.gpo_rd_en, bus.host_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rd +2: got rd_en=%b rvalid=%b want 0 0", bus.gpo_rd_en, bus.host_rvalid);
    end
    tick();
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd +3: got rvalid=%b rdata=%h want 1 a5", bus.host_rvalid, bus.host_rdata);
    end
    tick();
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd hold: got rvalid=%b rdata=%h want 0 a5", bus.host_rvalid, bus.host_rdata);
    end
    repeat (6) begin
      d = 8'($urandom);
      hold = $urandom_range(1, 2);
      host_write(d, "rand_rd");
      tick();
      bus.host_rd_req = 1'b1;
      tick();
      bus.host_rd_req = (hold == 2);
      checks++;
      if (bus.gpo_rd_en !== 1'b1) begin
        errors++;
        $display("FAIL rand rd_en +1: got %b want 1", bus.gpo_rd_en);
      end
      tick();
      bus.host_rd_req = 1'b0;
      checks++;
      if (bus.gpo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL rand rd_en +2 (hold %0d): got %b want 0", hold, bus.gpo_rd_en);
      end
      tick();
      checks++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, d}) begin
        errors++;
        $display("FAIL rand rd +3: got rvalid=%b rdata=%h want 1 %h", bus.host_rvalid, bus.host_rdata, d);
      end
      tick();
    end
  endtask
  task automatic test_collide();
    logic [7:0] old, e;
    old = cur;
    e = ~cur;
    bus.host_wr_req = 1'b1;
    bus.host_wdata = e;
    bus.host_rd_req = 1'b1;
    tick();
    bus.host_wr_req = 1'b0;
    bus.host_rd_req = 1'b0;
    checks++;
    if ({bus.gpo_wr_en, bus.gpo_rd_en, bus.host_ack} !== 3'b111) begin
      errors++;
      $display("FAIL collide strobes: got wr=%b rd=%b ack=%b want 1 1 1",
               bus.gpo_wr_en, bus.gpo_rd_en, bus.host_ack);
    end
    repeat (2) tick();
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, old}) begin
      errors++;
      $display("FAIL collide pre-write value: got rvalid=%b rdata=%h want 1 %h", bus.host_rvalid, bus.host_rdata, old);
    end
    bus.host_rd_req = 1'b1;
    tick();
    bus.host_rd_req = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL collide post-write value: got rvalid=%b rdata=%h want 1 %h", bus.host_rvalid, bus.host_rdata, e);
    end
    tick();
  endtask
  task automatic test_zero_ticks();
    load_entry(0, 8'($urandom));
    load_entry(1, 8'($urandom));
    run_seq(1, 0, 1'b0, 6, "zero_ticks");
    bus.seq_start = 1'b1;
    bus.seq_stop = 1'b1;
    tick();
    bus.seq_start = 1'b0;
    bus.seq_stop = 1'b0;
    repeat (3) begin
      checks++;
      if ({bus.gpo_wr_en, bus.seq_busy} !== 2'b00) begin
        errors++;
        $display("FAIL start+stop: got wr=%b busy=%b want 0 0", bus.gpo_wr_en, bus.seq_busy);
      end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) load_entry(i, 8'($urandom) | 8'h01);
    run_seq(3, 3, 1'b0, 10, "pre_reset");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) pat_m[i] = 8'h00;
    checks++;
    if (out_vec() !== '0) begin
      errors++;
      $display("FAIL async reset outputs: got %h want 0", out_vec());
    end
    tick();
    reset = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      if ({bus.gpo_wr_en, bus.seq_busy} !== 2'b00) begin
        errors++;
        $display("FAIL after reset activity: got wr=%b busy=%b want 0 0", bus.gpo_wr_en, bus.seq_busy);
      end
    end
    run_seq(0, 1, 1'b0, 4, "after_reset");
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_random_seq();
    test_loop_stop();
    test_host_arb();
    test_readback();
    test_collide();
    test_zero_ticks();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
